ex_alu_arb: RTL and testbench

- Shares one combinational execute ALU between NREQ issue requesters, one operation in flight at a time.
- Per-requester valid/ready request port; round-robin grant.
- Latches the winning operands, drives the ALU for one cycle and registers its outcome.
- Returns the outcome on a valid/ready response port tagged with the requester index. Sits between issue logic and the ALU in the EX stage.

---
 rtl/ex_alu_arb_if.sv | 58 +++++
 rtl/ex_alu_arb.sv | 151 +++++++++++++++
 tb/tb_ex_alu_arb.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_arb_if.sv
// Bus bundle for ex_alu_arb: packed request fan-in, ALU drive/return and response port.
// The slave modport is the arbiter's view; master is the issue/ALU/consumer side.
interface ex_alu_arb_if #(
  parameter int NREQ   = 2,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*OP_W-1:0]   req_aluop_i;
  logic [NREQ*SEL_W-1:0]  req_alusel_i;
  logic [NREQ*DATA_W-1:0] req_reg1_i;
  logic [NREQ*DATA_W-1:0] req_reg2_i;
  logic [NREQ*ADDR_W-1:0] req_wd_i;
  logic [NREQ-1:0]        req_wreg_i;

  logic [OP_W-1:0]        alu_aluop_o;
  logic [SEL_W-1:0]       alu_alusel_o;
  logic [DATA_W-1:0]      alu_reg1_o;
  logic [DATA_W-1:0]      alu_reg2_o;
  logic [ADDR_W-1:0]      alu_wd_o;
  logic                   alu_wreg_o;
  logic [ADDR_W-1:0]      alu_wd_i;
  logic                   alu_wreg_i;
  logic [DATA_W-1:0]      alu_wdata_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [ID_W-1:0]        rsp_id_o;
  logic [ADDR_W-1:0]      rsp_wd_o;
  logic                   rsp_wreg_o;
  logic [DATA_W-1:0]      rsp_wdata_o;
  logic                   busy_o;

  modport slave (
    input  req_valid_i, req_aluop_i, req_alusel_i, req_reg1_i, req_reg2_i, req_wd_i, req_wreg_i,
    output req_ready_o,
    output alu_aluop_o, alu_alusel_o, alu_reg1_o, alu_reg2_o, alu_wd_o, alu_wreg_o,
    input  alu_wd_i, alu_wreg_i, alu_wdata_i,
    output rsp_valid_o, rsp_id_o, rsp_wd_o, rsp_wreg_o, rsp_wdata_o,
    input  rsp_ready_i,
    output busy_o
  );

  modport master (
    output req_valid_i, req_aluop_i, req_alusel_i, req_reg1_i, req_reg2_i, req_wd_i, req_wreg_i,
    input  req_ready_o,
    input  alu_aluop_o, alu_alusel_o, alu_reg1_o, alu_reg2_o, alu_wd_o, alu_wreg_o,
    output alu_wd_i, alu_wreg_i, alu_wdata_i,
    input  rsp_valid_o, rsp_id_o, rsp_wd_o, rsp_wreg_o, rsp_wdata_o,
    output rsp_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/ex_alu_arb.sv
// Shares one combinational execute ALU between NREQ requesters, one op in flight (IDLE->EXEC->RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ex_alu_arb #(
  parameter int NREQ   = 2,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  ex_alu_arb_if.slave bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [NREQ-1:0]   req_ready;
  logic              accept;
  logic              exec;

  logic [OP_W-1:0]   op_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] reg1_q, reg2_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [ID_W-1:0]   id_q;

  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [ADDR_W-1:0] rsp_wd_q;
  logic              rsp_wreg_q;
  logic [DATA_W-1:0] rsp_wdata_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    // Scan downward so the lowest valid index is the last (winning) assignment.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[k]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // Walk from the farthest candidate back to ptr+1; the nearest valid one after the pointer wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (bus.req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: if (grant_vld) begin
        req_ready[grant_idx] = 1'b1;
        state_d              = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && grant_vld;
  assign exec   = (state_q == EXEC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the operand latch is a handful of flops, not a memory, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= '0;
      sel_q       <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_wd_q    <= '0;
      rsp_wreg_q  <= 1'b0;
      rsp_wdata_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= ID_W'(NREQ - 1);
`endif
    end else begin
      if (accept) begin
        op_q   <= bus.req_aluop_i[grant_idx*OP_W +: OP_W];
        sel_q  <= bus.req_alusel_i[grant_idx*SEL_W +: SEL_W];
        reg1_q <= bus.req_reg1_i[grant_idx*DATA_W +: DATA_W];
        reg2_q <= bus.req_reg2_i[grant_idx*DATA_W +: DATA_W];
        wd_q   <= bus.req_wd_i[grant_idx*ADDR_W +: ADDR_W];
        wreg_q <= bus.req_wreg_i[grant_idx];
        id_q   <= grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_q  <= grant_idx;
`endif
      end
      if (exec) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_wd_q    <= bus.alu_wd_i;
        rsp_wreg_q  <= bus.alu_wreg_i;
        rsp_wdata_q <= bus.alu_wdata_i;
      end else if ((state_q == RESP) && bus.rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // The ALU sees zeros except during the single EXEC cycle.
  assign bus.alu_aluop_o  = exec ? op_q   : '0;
  assign bus.alu_alusel_o = exec ? sel_q  : '0;
  assign bus.alu_reg1_o   = exec ? reg1_q : '0;
  assign bus.alu_reg2_o   = exec ? reg2_q : '0;
  assign bus.alu_wd_o     = exec ? wd_q   : '0;
  assign bus.alu_wreg_o   = exec & wreg_q;

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_wd_o     = rsp_wd_q;
  assign bus.rsp_wreg_o   = rsp_wreg_q;
  assign bus.rsp_wdata_o  = rsp_wdata_q;
  assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_ex_alu_arb.sv
// Self-checking bench for ex_alu_arb: directed scenarios plus random traffic against a
// transaction-level model (accept when idle, response from accept+2, retire on rsp_ready).
module tb_ex_alu_arb;
  localparam int NREQ   = 2;
  localparam int OP_W   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [OP_W-1:0] OP_ADD = 8'h20;
  localparam logic [OP_W-1:0] OP_AND = 8'h24;
  localparam logic [OP_W-1:0] OP_OR  = 8'h25;
  localparam logic [OP_W-1:0] OP_XOR = 8'h26;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    int                id;
  } txn_t;

  logic clk;
  logic rst;

  ex_alu_arb_if #(.NREQ(NREQ), .OP_W(OP_W), .SEL_W(SEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_alu_arb #(.NREQ(NREQ), .OP_W(OP_W), .SEL_W(SEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU: a small combinational unit that echoes the destination fields.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_wdata_i = alu_fn(bus.alu_aluop_o, bus.alu_reg1_o, bus.alu_reg2_o);
  assign bus.alu_wd_i    = bus.alu_wd_o;
  assign bus.alu_wreg_i  = bus.alu_wreg_o;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit   m_have;
  int   m_acc;
  int   m_last;
  int   cyc;
  txn_t m_cur;
  int   g_obs[$];

  function automatic int m_winner(input logic [NREQ-1:0] v);
    int w;
    w = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (w < 0 && v[k]) w = k;
`else
    for (int k = 1; k <= NREQ; k++) if (w < 0 && v[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_have = 1'b0;
    m_acc  = -10;
    m_last = NREQ - 1;
  endtask

  task automatic set_req(input int k, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] r1,
                         input logic [DATA_W-1:0] r2, input logic [ADDR_W-1:0] wd, input logic wreg);
    bus.req_aluop_i[k*OP_W +: OP_W]       = op;
    bus.req_alusel_i[k*SEL_W +: SEL_W]    = SEL_W'($urandom);
    bus.req_reg1_i[k*DATA_W +: DATA_W]    = r1;
    bus.req_reg2_i[k*DATA_W +: DATA_W]    = r2;
    bus.req_wd_i[k*ADDR_W +: ADDR_W]      = wd;
    bus.req_wreg_i[k]                     = wreg;
  endtask

  task automatic rand_req(input int k);
    logic [OP_W-1:0] ops [4];
    ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_OR; ops[3] = OP_XOR;
    set_req(k, ops[$urandom_range(0, 3)], $urandom, $urandom, ADDR_W'($urandom), 1'($urandom));
  endtask

  // One clock cycle: check outputs against the model, then advance DUT and model together.
  task automatic cycle();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] exp_ready;
    int   w;
    bit   rspv;
    bit   ex;
    txn_t t;
    #1;
    v = bus.req_valid_i;
    w = m_have ? -1 : m_winner(v);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", bus.req_ready_o, exp_ready);
    check("busy", bus.busy_o, m_have);
    rspv = m_have && (cyc >= m_acc + 2);
    check("rsp_valid", bus.rsp_valid_o, rspv);
    if (rspv) begin
      check("rsp_id", bus.rsp_id_o, m_cur.id);
      check("rsp_wd", bus.rsp_wd_o, m_cur.wd);
      check("rsp_wreg", bus.rsp_wreg_o, m_cur.wreg);
      check("rsp_wdata", bus.rsp_wdata_o, alu_fn(m_cur.op, m_cur.r1, m_cur.r2));
    end
    ex = m_have && (cyc == m_acc + 1);
    check("alu_drive",
          {bus.alu_aluop_o, bus.alu_alusel_o, bus.alu_reg1_o, bus.alu_reg2_o, bus.alu_wd_o, bus.alu_wreg_o},
          ex ? {m_cur.op, m_cur.sel, m_cur.r1, m_cur.r2, m_cur.wd, m_cur.wreg} : '0);
    for (int k = 0; k < NREQ; k++) if (bus.req_ready_o[k]) g_obs.push_back(k);
    if (w >= 0) begin
      t.op   = bus.req_aluop_i[w*OP_W +: OP_W];
      t.sel  = bus.req_alusel_i[w*SEL_W +: SEL_W];
      t.r1   = bus.req_reg1_i[w*DATA_W +: DATA_W];
      t.r2   = bus.req_reg2_i[w*DATA_W +: DATA_W];
      t.wd   = bus.req_wd_i[w*ADDR_W +: ADDR_W];
      t.wreg = bus.req_wreg_i[w];
      t.id   = w;
    end
    @(posedge clk);
    if (rst) begin
      if (rspv && bus.rsp_ready_i) m_have = 1'b0;
      else if (w >= 0) begin
        m_have = 1'b1;
        m_acc  = cyc;
        m_cur  = t;
        m_last = w;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (5) cycle();
  endtask

  initial begin
    rst             = 1'b0;
    bus.req_valid_i = '0;
    bus.req_aluop_i = '0;
    bus.req_alusel_i = '0;
    bus.req_reg1_i  = '0;
    bus.req_reg2_i  = '0;
    bus.req_wd_i    = '0;
    bus.req_wreg_i  = '0;
    bus.rsp_ready_i = 1'b0;
    model_reset();
    cyc = 0;

    // Reset state
    #2;
    check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("rst_rsp_fields", {bus.rsp_id_o, bus.rsp_wd_o, bus.rsp_wreg_o, bus.rsp_wdata_o}, '0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_ready", bus.req_ready_o, '0);
    check("rst_alu", {bus.alu_aluop_o, bus.alu_alusel_o, bus.alu_reg1_o, bus.alu_reg2_o,
                      bus.alu_wd_o, bus.alu_wreg_o}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // AND from requester 0: ready at cycle 0, response at cycle 2, idle at cycle 3
    set_req(0, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, 1'b1);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 1'b1;
    #1;
    check("and_ready", bus.req_ready_o, 2'b01);
    cycle();
    bus.req_valid_i = '0;
    cycle();
    check("and_rsp_valid", bus.rsp_valid_o, 1'b1);
    check("and_wdata", bus.rsp_wdata_o, 32'h00F0_00F0);
    check("and_wd", bus.rsp_wd_o, 5'd3);
    check("and_wreg", bus.rsp_wreg_o, 1'b1);
    check("and_id", bus.rsp_id_o, 1'b0);
    cycle();
    check("and_busy_low", bus.busy_o, 1'b0);

    // Both requesters continuously valid
    rand_req(0);
    rand_req(1);
    g_obs.delete();
    bus.req_valid_i = 2'b11;
    repeat (12) cycle();
    check("contend_count", g_obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("contend_grant", g_obs[i], 0);
`else
      check("contend_grant", g_obs[i], (i % 2 == 0) ? 1 : 0);
`endif
    end
    bus.req_valid_i = 2'b10;
    repeat (3) cycle();
    check("drop_count", g_obs.size(), 5);
    check("drop_grant", g_obs[g_obs.size()-1], 1);
    drain();

    // OR from requester 1 with back-pressure for 5 cycles
    set_req(1, OP_OR, 32'h1234_0000, 32'h0000_5678, 5'd7, 1'b1);
    rand_req(0);
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 1'b0;
    cycle();
    bus.req_valid_i = 2'b11;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.rsp_valid_o, 1'b1);
      check("hold_wdata", bus.rsp_wdata_o, 32'h1234_5678);
      check("hold_ready", bus.req_ready_o, '0);
      cycle();
    end
    bus.rsp_ready_i = 1'b1;
    cycle();
    check("hold_done", bus.rsp_valid_o, 1'b0);
    drain();

    // Reset while in EXEC
    rand_req(1);
    bus.req_valid_i = 2'b10;
    cycle();
    bus.req_valid_i = '0;
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_alu", {bus.alu_aluop_o, bus.alu_alusel_o, bus.alu_reg1_o, bus.alu_reg2_o,
                         bus.alu_wd_o, bus.alu_wreg_o}, '0);
    repeat (2) cycle();
    rst = 1'b1;
    rand_req(0);
    rand_req(1);
    bus.req_valid_i = 2'b11;
    #1;
    check("midrst_grant0", bus.req_ready_o, 2'b01);
    cycle();
    drain();

    // Operands change after accept: latched values must be used
    set_req(0, OP_XOR, 32'hFFFF_FFFF, 32'h0000_FFFF, 5'd9, 1'b0);
    bus.req_valid_i = 2'b01;
    cycle();
    bus.req_reg1_i[0 +: DATA_W] = '0;
    bus.req_valid_i = '0;
    cycle();
    check("latch_valid", bus.rsp_valid_o, 1'b1);
    check("latch_wdata", bus.rsp_wdata_o, 32'hFFFF_0000);
    check("latch_wreg", bus.rsp_wreg_o, 1'b0);
    cycle();
    drain();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NREQ; k++) rand_req(k);
      bus.req_valid_i = NREQ'($urandom);
      bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
